// File: rtl/avg_result_sink.sv
// Consumer end of the moving-average stream. Results are buffered in a small FIFO and shown on the LEDs for HOLD_CYCLES each.
// The upstream cannot stall. A result that arrives while the FIFO is full, with no pop that cycle, is dropped and counted.

module avg_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic [W-1:0]           push_dat,
   input  logic                   pop,
   output logic [W-1:0]           pop_dat,
   output logic [$clog2(DEPTH):0] count
);
   // Head is read combinationally. count is registered and is the only full/empty source.
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   assign pop_dat = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_dat;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

module avg_result_sink #(
   parameter int WIDTH       = 32,
   parameter int DEPTH       = 8,
   parameter int HOLD_CYCLES = 100_000_000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   input  logic signed [WIDTH-1:0] in_avg,
   output logic [7:0]              leds,
   output logic                    showing,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    overflow,
   output logic [7:0]              drop_cnt
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] FULL      = CW'(DEPTH);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] SHOW = 1'b1;

   logic [0:0]    state;
   logic [HW-1:0] hold;
   logic [7:0]    head;
   logic          full;
   logic          nonempty;
   logic          push;
   logic          pop;
   logic          drop;
   logic          unused_hi;

   // Only the low byte is ever displayed, so only the low byte is buffered.
   assign unused_hi = ^in_avg[WIDTH-1:8];

   assign full     = (count == FULL);
   assign nonempty = (count != '0);
   assign pop      = nonempty && ((state == IDLE) || (hold == '0));
   assign push     = in_valid && (!full || pop);
   assign drop     = in_valid && full && !pop;

   avg_fifo #(
      .W     (8),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push),
      .push_dat (in_avg[7:0]),
      .pop      (pop),
      .pop_dat  (head),
      .count    (count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         hold    <= '0;
         showing <= 1'b0;
         leds    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  state   <= SHOW;
                  showing <= 1'b1;
                  hold    <= HOLD_LOAD;
               end
            end
            default: begin
               // Reload on expiry gives back-to-back display with no gap.
               if (hold != '0) begin
                  hold <= hold - HW'(1);
               end else if (pop) begin
                  hold <= HOLD_LOAD;
               end else begin
                  state   <= IDLE;
                  showing <= 1'b0;
               end
            end
         endcase
         if (pop) begin
            leds <= head;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else if (drop) begin
         overflow <= 1'b1;
         if (drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
         end
      end
   end
endmodule

// File: tb/tb_avg_result_sink.sv
// Scoreboard bench for avg_result_sink: instance a (HOLD_CYCLES=4) and instance b (HOLD_CYCLES=100).
module tb_avg_result_sink;
   logic        clk = 1'b0;
   logic        rst_a_n, rst_b_n, vld_a, vld_b;
   logic [31:0] avg_a, avg_b;
   logic [7:0]  leds_a, leds_b, drop_a, drop_b;
   logic        show_a, show_b, ovf_a, ovf_b;
   logic [3:0]  cnt_a, cnt_b;

   int checks   = 0;
   int failures = 0;

   logic [7:0] exp_a[$];
   logic [7:0] exp_b[$];
   logic [7:0] cur_a = 8'h00;
   logic [7:0] cur_b = 8'h00;
   logic       prev_a = 1'b0;
   logic       prev_b = 1'b0;
   int         since_a = 0;
   int         since_b = 0;

   always #5 clk = ~clk;

   avg_result_sink #(.WIDTH(32), .DEPTH(8), .HOLD_CYCLES(4)) dut_a (
      .clk(clk), .rst_n(rst_a_n), .in_valid(vld_a), .in_avg(avg_a), .leds(leds_a),
      .showing(show_a), .count(cnt_a), .overflow(ovf_a), .drop_cnt(drop_a)
   );

   avg_result_sink #(.WIDTH(32), .DEPTH(8), .HOLD_CYCLES(100)) dut_b (
      .clk(clk), .rst_n(rst_b_n), .in_valid(vld_b), .in_avg(avg_b), .leds(leds_b),
      .showing(show_b), .count(cnt_b), .overflow(ovf_b), .drop_cnt(drop_b)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_reset(input string tag, input logic [7:0] l, input logic s, input logic [3:0] c,
                            input logic o, input logic [7:0] d);
      chk({tag, "_rst_leds"}, l, 0);
      chk({tag, "_rst_showing"}, s, 0);
      chk({tag, "_rst_count"}, c, 0);
      chk({tag, "_rst_overflow"}, o, 0);
      chk({tag, "_rst_drop_cnt"}, d, 0);
   endtask

   // Drive at a negedge; the value is sampled at the following posedge.
   task automatic push_a(input logic [31:0] v, input bit acc);
      vld_a = 1'b1;
      avg_a = v;
      if (acc) exp_a.push_back(v[7:0]);
      @(negedge clk);
      vld_a = 1'b0;
   endtask

   task automatic push_b(input logic [31:0] v, input bit acc);
      vld_b = 1'b1;
      avg_b = v;
      if (acc) exp_b.push_back(v[7:0]);
      @(negedge clk);
      vld_b = 1'b0;
   endtask

   task automatic wait_idle_a(input int budget);
      bit done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         @(negedge clk);
         done = !show_a && (exp_a.size() == 0);
      end
      if (!done) begin
         checks++;
         failures++;
         $display("FAIL a_drain_timeout: queue=%0d showing=%0b required empty and idle", exp_a.size(), show_a);
      end
   endtask

   task automatic wait_idle_b(input int budget);
      bit done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         @(negedge clk);
         done = !show_b && (exp_b.size() == 0);
      end
      if (!done) begin
         checks++;
         failures++;
         $display("FAIL b_drain_timeout: queue=%0d showing=%0b required empty and idle", exp_b.size(), show_b);
      end
   endtask

   // Monitor a: a display starts when showing rises or when a hold of 4 cycles has elapsed.
   always @(negedge clk) begin
      if (!rst_a_n) begin
         prev_a  <= 1'b0;
         since_a <= 0;
         cur_a   <= 8'h00;
      end else begin
         if (show_a && (!prev_a || since_a == 4)) begin
            if (exp_a.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL a_unexpected_display: leds=%0h with no expected value", leds_a);
            end else begin
               chk("a_display_value", leds_a, exp_a[0]);
               cur_a <= exp_a.pop_front();
            end
            since_a <= 1;
         end else begin
            if (show_a) chk("a_hold_value", leds_a, cur_a);
            else chk("a_idle_leds", leds_a, cur_a);
            if (prev_a && !show_a) chk("a_hold_length", since_a, 4);
            since_a <= since_a + 1;
         end
         prev_a <= show_a;
      end
   end

   // Monitor b: same, with a hold of 100 cycles.
   always @(negedge clk) begin
      if (!rst_b_n) begin
         prev_b  <= 1'b0;
         since_b <= 0;
         cur_b   <= 8'h00;
      end else begin
         if (show_b && (!prev_b || since_b == 100)) begin
            if (exp_b.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL b_unexpected_display: leds=%0h with no expected value", leds_b);
            end else begin
               chk("b_display_value", leds_b, exp_b[0]);
               cur_b <= exp_b.pop_front();
            end
            since_b <= 1;
         end else begin
            if (show_b) chk("b_hold_value", leds_b, cur_b);
            else chk("b_idle_leds", leds_b, cur_b);
            if (prev_b && !show_b) chk("b_hold_length", since_b, 100);
            since_b <= since_b + 1;
         end
         prev_b <= show_b;
      end
   end

   initial begin
      rst_a_n = 1'b0;
      rst_b_n = 1'b0;
      vld_a   = 1'b0;
      vld_b   = 1'b0;
      avg_a   = '0;
      avg_b   = '0;
      #2;
      chk_reset("a", leds_a, show_a, cnt_a, ovf_a, drop_a);
      chk_reset("b", leds_b, show_b, cnt_b, ovf_b, drop_b);
      fork
         begin
            @(negedge clk);
            rst_a_n = 1'b1;
            @(negedge clk);
            // Single value: pushed at E0, displayed from E1.
            push_a(32'd5, 1'b1);
            @(posedge clk);
            #1;
            chk("a_single_latency_leds", leds_a, 8'h05);
            chk("a_single_latency_showing", show_a, 1);
            wait_idle_a(100);
            chk("a_single_final_leds", leds_a, 8'h05);
            // Stream of consecutive moving averages.
            for (int k = 3; k <= 6; k++) push_a(k, 1'b1);
            wait_idle_a(100);
            chk("a_stream_final_leds", leds_a, 8'h06);
            chk("a_stream_final_count", cnt_a, 0);
            // Negative value, then asynchronous reset in the middle of its hold.
            push_a(32'hFFFF_FFFF, 1'b1);
            @(posedge clk);
            #1;
            chk("a_negative_leds", leds_a, 8'hFF);
            @(posedge clk);
            #2;
            rst_a_n = 1'b0;
            #1;
            chk_reset("a_mid", leds_a, show_a, cnt_a, ovf_a, drop_a);
            exp_a.delete();
            @(posedge clk);
            #2;
            rst_a_n = 1'b1;
            @(negedge clk);
            push_a(32'd7, 1'b1);
            @(posedge clk);
            #1;
            chk("a_after_reset_leds", leds_a, 8'h07);
            chk("a_after_reset_showing", show_a, 1);
            wait_idle_a(100);
            // Continuous input at HOLD=4: accepted while filling (k<=10), then only on pop cycles.
            for (int k = 0; k < 420; k++) push_a(k, (k <= 10) || (k % 4 == 1));
            chk("a_sat_drop_cnt", drop_a, 8'hFF);
            chk("a_sat_overflow", ovf_a, 1);
            chk("a_sat_count_full", cnt_a, 8);
            wait_idle_a(200);
            chk("a_sat_drop_cnt_held", drop_a, 8'hFF);
         end
         begin
            @(negedge clk);
            rst_b_n = 1'b1;
            @(negedge clk);
            // 1 popped at E1, 2..9 fill the FIFO, 10 dropped.
            for (int k = 0; k < 10; k++) push_b(k + 1, k <= 8);
            chk("b_overflow", ovf_b, 1);
            chk("b_drop_cnt", drop_b, 1);
            chk("b_count_full", cnt_b, 8);
            wait_idle_b(1200);
            chk("b_final_leds", leds_b, 8'h09);
         end
      join
      chk("a_queue_empty", exp_a.size(), 0);
      chk("b_queue_empty", exp_b.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
